// File: rtl/dynamic_input_route_buffer_para.sv
// rtl/dynamic_input_route_buffer_para.sv - credit-based input FIFO that routes packets to two dynamic outputs
// Define DYNAMIC_INPUT_OVERFLOW_CHECK_EN to enable the sticky credit-violation flag on overflow_err_out.
`ifndef DATA_WIDTH
`define DATA_WIDTH 64
`endif
`ifndef CHIP_ID_WIDTH
`define CHIP_ID_WIDTH 14
`endif
`ifndef XY_WIDTH
`define XY_WIDTH 8
`endif
`ifndef PAYLOAD_LEN
`define PAYLOAD_LEN 8
`endif

module dynamic_input_route_buffer_para #(
   parameter int BUFFER_DEPTH = 4,
   parameter int PTR_WIDTH    = 2
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [`DATA_WIDTH-1:0]    data_in,
   input  logic                      valid_in,
   input  logic [`CHIP_ID_WIDTH-1:0] my_chip_id_in,
   input  logic [`XY_WIDTH-1:0]      my_loc_x_in,
   input  logic [`XY_WIDTH-1:0]      my_loc_y_in,
   input  logic                      thanks_0_in,
   input  logic                      thanks_1_in,
   output logic [`DATA_WIDTH-1:0]    data_out,
   output logic                      valid_out,
   output logic                      route_req_0_out,
   output logic                      route_req_1_out,
   output logic                      tail_out,
   output logic                      yummy_out,
   output logic                      overflow_err_out
);
   localparam int DW     = `DATA_WIDTH;
   localparam int CID    = `CHIP_ID_WIDTH;
   localparam int XYW    = `XY_WIDTH;
   localparam int PL     = `PAYLOAD_LEN;
   localparam int LEN_HI = DW - CID - 2*XYW - 4;
   localparam int LEN_LO = DW - CID - 2*XYW - 3 - PL;

   typedef enum logic {HDR, BODY} state_t;

   logic [DW-1:0]        mem_q [BUFFER_DEPTH];
   logic [PTR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [PTR_WIDTH:0]   count_q, count_d;
   state_t               state_q, state_d;
   logic [PL-1:0]        remaining_q, remaining_d;
   logic                 route_q, route_d;
   logic                 yummy_q;
   logic                 push, pop, full, route_hdr, sel_route;
   logic [PL-1:0]        hdr_len;

   assign full      = (count_q == (PTR_WIDTH+1)'(BUFFER_DEPTH));
   assign push      = valid_in & ~full;
   assign hdr_len   = data_out[LEN_HI:LEN_LO];
   assign route_hdr = (data_out[DW-1 -: CID] == my_chip_id_in) &&
                      (data_out[DW-CID-1 -: XYW] == my_loc_x_in) &&
                      (data_out[DW-CID-XYW-1 -: XYW] == my_loc_y_in);
   assign yummy_out = yummy_q;

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= data_in;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         state_q     <= HDR;
         remaining_q <= '0;
         route_q     <= 1'b0;
         yummy_q     <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         state_q     <= state_d;
         remaining_q <= remaining_d;
         route_q     <= route_d;
         yummy_q     <= pop;
      end
   end

   always_comb begin
      wr_ptr_d    = push ? wr_ptr_q + PTR_WIDTH'(1) : wr_ptr_q;
      rd_ptr_d    = pop  ? rd_ptr_q + PTR_WIDTH'(1) : rd_ptr_q;
      count_d     = count_q;
      if (push && !pop) count_d = count_q + (PTR_WIDTH+1)'(1);
      if (!push && pop) count_d = count_q - (PTR_WIDTH+1)'(1);
      state_d     = state_q;
      remaining_d = remaining_q;
      route_d     = route_q;
      if (pop) begin
         if (state_q == HDR) begin
            if (hdr_len != '0) begin
               route_d     = route_hdr;
               remaining_d = hdr_len;
               state_d     = BODY;
            end
         end else begin
            remaining_d = remaining_q - PL'(1);
            if (remaining_q == PL'(1)) state_d = HDR;
         end
      end
   end

   // Both thanks in one cycle still pop once: only the owning output's thanks is looked at.
   always_comb begin
      data_out        = mem_q[rd_ptr_q];
      valid_out       = (count_q != '0);
      sel_route       = (state_q == HDR) ? route_hdr : route_q;
      route_req_0_out = valid_out & ~sel_route;
      route_req_1_out = valid_out & sel_route;
      tail_out        = valid_out & ((state_q == HDR) ? (hdr_len == '0) : (remaining_q == PL'(1)));
      pop             = valid_out & (sel_route ? thanks_1_in : thanks_0_in);
   end

`ifdef DYNAMIC_INPUT_OVERFLOW_CHECK_EN
   logic overflow_q;
   always_ff @(posedge clk) begin
      if (reset)                overflow_q <= 1'b0;
      else if (valid_in & full) overflow_q <= 1'b1;
   end
   assign overflow_err_out = overflow_q;
`else
   assign overflow_err_out = 1'b0;
`endif

endmodule

// File: tb/tb_dynamic_input_route_buffer_para.sv
// tb/tb_dynamic_input_route_buffer_para.sv - directed self-checking bench for the dynamic input route buffer
`ifndef DATA_WIDTH
`define DATA_WIDTH 64
`endif
`ifndef CHIP_ID_WIDTH
`define CHIP_ID_WIDTH 14
`endif
`ifndef XY_WIDTH
`define XY_WIDTH 8
`endif
`ifndef PAYLOAD_LEN
`define PAYLOAD_LEN 8
`endif

module tb_dynamic_input_route_buffer_para;
   logic                      clk = 1'b0;
   logic                      reset;
   logic [`DATA_WIDTH-1:0]    data_in;
   logic                      valid_in;
   logic [`CHIP_ID_WIDTH-1:0] my_chip_id_in;
   logic [`XY_WIDTH-1:0]      my_loc_x_in;
   logic [`XY_WIDTH-1:0]      my_loc_y_in;
   logic                      thanks_0_in;
   logic                      thanks_1_in;
   logic [`DATA_WIDTH-1:0]    data_out;
   logic                      valid_out;
   logic                      route_req_0_out;
   logic                      route_req_1_out;
   logic                      tail_out;
   logic                      yummy_out;
   logic                      overflow_err_out;

   int checks   = 0;
   int failures = 0;

`ifdef DYNAMIC_INPUT_OVERFLOW_CHECK_EN
   localparam logic OVF_EXP = 1'b1;
`else
   localparam logic OVF_EXP = 1'b0;
`endif

   dynamic_input_route_buffer_para #(.BUFFER_DEPTH(4), .PTR_WIDTH(2)) dut (
      .clk(clk), .reset(reset), .data_in(data_in), .valid_in(valid_in),
      .my_chip_id_in(my_chip_id_in), .my_loc_x_in(my_loc_x_in), .my_loc_y_in(my_loc_y_in),
      .thanks_0_in(thanks_0_in), .thanks_1_in(thanks_1_in),
      .data_out(data_out), .valid_out(valid_out),
      .route_req_0_out(route_req_0_out), .route_req_1_out(route_req_1_out),
      .tail_out(tail_out), .yummy_out(yummy_out), .overflow_err_out(overflow_err_out)
   );

   always #5 clk = ~clk;

   // Header layout for 64-bit flits: chip[63:50] x[49:42] y[41:34] len[30:23], tag in [7:0].
   function automatic logic [63:0] hdr(input logic [13:0] c, input logic [7:0] x, input logic [7:0] y,
                                       input logic [7:0] len, input logic [7:0] tag);
      logic [63:0] d;
      d        = 64'h0;
      d[63:50] = c;
      d[49:42] = x;
      d[41:34] = y;
      d[30:23] = len;
      d[7:0]   = tag;
      return d;
   endfunction

   function automatic logic [4:0] obs();
      return {valid_out, route_req_0_out, route_req_1_out, tail_out, yummy_out};
   endfunction

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      valid_in    = 1'b0;
      data_in     = '0;
      thanks_0_in = 1'b0;
      thanks_1_in = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({obs(), overflow_err_out} !== 6'b0) begin
         failures++;
         $display("FAIL reset_state: got %b want 000000", {obs(), overflow_err_out});
      end
   endtask

   task automatic test_local_packet();
      logic [63:0] f [3];
      logic [4:0]  e [3];
      f[0] = hdr(14'd5, 8'd2, 8'd3, 8'd2, 8'h11);
      f[1] = 64'h0000_0000_0000_00B1;
      f[2] = 64'h0000_0000_0000_00B2;
      e[0] = 5'b10100; e[1] = 5'b10101; e[2] = 5'b10111;
      do_reset();
      valid_in = 1'b1; data_in = f[0];
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (obs() !== e[i] || data_out !== f[i]) begin
            failures++;
            $display("FAIL local_flit%0d: got %b/%h want %b/%h", i, obs(), data_out, e[i], f[i]);
         end
         thanks_1_in = 1'b1;
         if (i < 2) data_in = f[i+1]; else valid_in = 1'b0;
      end
      tick();
      checks++;
      if (obs() !== 5'b00001) begin
         failures++;
         $display("FAIL local_drain: got %b want 00001", obs());
      end
      thanks_1_in = 1'b0;
      tick();
      checks++;
      if (obs() !== 5'b00000) begin
         failures++;
         $display("FAIL local_yummy_end: got %b want 00000", obs());
      end
   endtask

   task automatic test_remote_single();
      do_reset();
      valid_in = 1'b1; data_in = hdr(14'd9, 8'd1, 8'd1, 8'd0, 8'h22);
      tick();
      checks++;
      if (obs() !== 5'b11010) begin
         failures++;
         $display("FAIL remote_hdr: got %b want 11010", obs());
      end
      valid_in = 1'b0; thanks_0_in = 1'b1;
      tick();
      checks++;
      if (obs() !== 5'b00001) begin
         failures++;
         $display("FAIL remote_popped: got %b want 00001", obs());
      end
      thanks_0_in = 1'b0;
      valid_in = 1'b1; data_in = hdr(14'd5, 8'd2, 8'd3, 8'd0, 8'h23);
      tick();
      valid_in = 1'b0;
      checks++;
      if (obs() !== 5'b10110) begin
         failures++;
         $display("FAIL remote_then_hdr: got %b want 10110", obs());
      end
   endtask

   task automatic test_overflow();
      logic [63:0] f [5];
      for (int i = 0; i < 5; i++) f[i] = hdr(14'd5, 8'd2, 8'd3, 8'd0, 8'(8'h30 + i));
      do_reset();
      for (int i = 0; i < 5; i++) begin
         valid_in = 1'b1; data_in = f[i];
         tick();
      end
      valid_in = 1'b0;
      checks++;
      if (overflow_err_out !== OVF_EXP) begin
         failures++;
         $display("FAIL ovf_set: got %b want %b", overflow_err_out, OVF_EXP);
      end
      thanks_1_in = 1'b1;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (valid_out !== 1'b1 || data_out !== f[i]) begin
            failures++;
            $display("FAIL ovf_drain%0d: got %b/%h want 1/%h", i, valid_out, data_out, f[i]);
         end
         tick();
      end
      thanks_1_in = 1'b0;
      checks++;
      if (valid_out !== 1'b0 || overflow_err_out !== OVF_EXP) begin
         failures++;
         $display("FAIL ovf_dropped_sticky: got %b%b want 0%b", valid_out, overflow_err_out, OVF_EXP);
      end
   endtask

   task automatic test_wrong_thanks();
      logic [63:0] body;
      body = 64'h0000_0000_0000_00C1;
      do_reset();
      valid_in = 1'b1; data_in = hdr(14'd9, 8'd1, 8'd1, 8'd1, 8'h44);
      tick();
      data_in = body;
      tick();
      valid_in = 1'b0; thanks_1_in = 1'b1;
      tick();
      checks++;
      if (obs() !== 5'b11000 || data_out[7:0] !== 8'h44) begin
         failures++;
         $display("FAIL wrong_thanks: got %b/%h want 11000/44", obs(), data_out[7:0]);
      end
      thanks_0_in = 1'b1;
      tick();
      thanks_0_in = 1'b0; thanks_1_in = 1'b0;
      checks++;
      if (obs() !== 5'b11011 || data_out !== body) begin
         failures++;
         $display("FAIL both_thanks: got %b/%h want 11011/%h", obs(), data_out, body);
      end
      tick();
      checks++;
      if (obs() !== 5'b11010) begin
         failures++;
         $display("FAIL single_pop: got %b want 11010", obs());
      end
   endtask

   task automatic test_back_to_back();
      logic [63:0] f [6];
      logic [4:0]  e [6];
      f[0] = hdr(14'd9, 8'd1, 8'd1, 8'd1, 8'hA0);
      f[1] = 64'h0000_0000_0000_00B1;
      f[2] = hdr(14'd5, 8'd2, 8'd3, 8'd0, 8'hC0);
      f[3] = hdr(14'd9, 8'd1, 8'd1, 8'd0, 8'hD0);
      f[4] = hdr(14'd5, 8'd2, 8'd3, 8'd0, 8'hE0);
      f[5] = hdr(14'd9, 8'd4, 8'd4, 8'd0, 8'hF0);
      e[0] = 5'b11000; e[1] = 5'b11011; e[2] = 5'b10111;
      e[3] = 5'b11011; e[4] = 5'b10111; e[5] = 5'b11011;
      do_reset();
      valid_in = 1'b1; data_in = f[0];
      for (int i = 0; i < 6; i++) begin
         tick();
         checks++;
         if (obs() !== e[i] || data_out !== f[i]) begin
            failures++;
            $display("FAIL b2b_flit%0d: got %b/%h want %b/%h", i, obs(), data_out, e[i], f[i]);
         end
         thanks_0_in = 1'b1; thanks_1_in = 1'b1;
         if (i < 5) data_in = f[i+1]; else valid_in = 1'b0;
      end
      tick();
      thanks_0_in = 1'b0; thanks_1_in = 1'b0;
      checks++;
      if (obs() !== 5'b00001) begin
         failures++;
         $display("FAIL b2b_empty: got %b want 00001", obs());
      end
   endtask

   task automatic test_reset_mid_packet();
      logic [63:0] nh;
      nh = hdr(14'd9, 8'd7, 8'd7, 8'd0, 8'h66);
      do_reset();
      valid_in = 1'b1; data_in = hdr(14'd5, 8'd2, 8'd3, 8'd3, 8'h55);
      tick();
      data_in = 64'h0000_0000_0000_00D1; thanks_1_in = 1'b1;
      tick();
      data_in = 64'h0000_0000_0000_00D2;
      tick();
      valid_in = 1'b0; thanks_1_in = 1'b0; reset = 1'b1;
      tick();
      checks++;
      if (obs() !== 5'b00000) begin
         failures++;
         $display("FAIL midreset_state: got %b want 00000", obs());
      end
      reset = 1'b0;
      valid_in = 1'b1; data_in = nh;
      tick();
      valid_in = 1'b0;
      checks++;
      if (obs() !== 5'b11010 || data_out !== nh) begin
         failures++;
         $display("FAIL midreset_newpkt: got %b/%h want 11010/%h", obs(), data_out, nh);
      end
   endtask

   initial begin
      reset         = 1'b1;
      my_chip_id_in = 14'd5;
      my_loc_x_in   = 8'd2;
      my_loc_y_in   = 8'd3;
      idle_inputs();
      test_reset();
      test_local_packet();
      test_remote_single();
      test_overflow();
      test_wrong_thanks();
      test_back_to_back();
      test_reset_mid_packet();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
